// File: rtl/display_mux_7seg.sv
`default_nettype none
// ============================================================================
// Module      : display_mux_7seg
// Description : Time-multiplexed driver for N_DIGITS seven-segment digits.
//               A prescaler holds each digit for REFRESH_DIV clock cycles.
//               The digit index walks 0 .. N_DIGITS-1 and then wraps.
//               Input data is captured into a shadow register once per
//               frame, so one frame never mixes old and new data.
//               The segment, dp and anode outputs are registered and lag
//               the digit index by one cycle.
// Optional    : define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//               Digit 0 is never blanked.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               value  - 4*N_DIGITS digit codes, nibble k = digit k
//               dp_in  - decimal point request per digit
//               hex_en - 1: decode 10..15 as A..F; 0: 10..15 blank
//               seg    - segments abcdefg (seg[6] = a), registered
//               dp     - decimal point, registered
//               anode  - one-hot digit enable, registered
// Revision    : 1.0 - initial release
// ============================================================================
module display_mux_7seg #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    hex_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     anode
);

    localparam int                  c_cw      = $clog2(REFRESH_DIV);
    localparam int                  c_iw      = $clog2(N_DIGITS);
    localparam logic [c_cw-1:0]     c_cnt_max = c_cw'(REFRESH_DIV - 1);
    localparam logic [c_iw-1:0]     c_idx_max = c_iw'(N_DIGITS - 1);
    localparam logic                c_pol     = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] c_one     = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [c_cw-1:0]        r_cnt;
    logic [c_iw-1:0]        r_idx;
    logic                   r_first;
    logic [4*N_DIGITS-1:0]  r_val_sh;
    logic [N_DIGITS-1:0]    r_dp_sh;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [N_DIGITS-1:0]    r_anode;

    logic                   w_tick;
    logic                   w_load;
    logic [4*N_DIGITS-1:0]  w_val_src;
    logic [N_DIGITS-1:0]    w_dp_src;
    logic [3:0]             w_nib;
    logic [6:0]             w_dec;
    logic                   w_blank_cur;
    logic [6:0]             w_seg_pos;
    logic [N_DIGITS-1:0]    w_onehot;

    assign w_tick = (r_cnt == c_cnt_max);
    assign w_load = r_first | (w_tick & (r_idx == c_idx_max));

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // r_first marks the first edge after reset release, where the shadow
    // register is loaded regardless of the frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= 1'b1;
            r_val_sh <= '0;
            r_dp_sh  <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_load) begin
                r_val_sh <= value;
                r_dp_sh  <= dp_in;
            end
        end
    end

    // On the first post-reset edge the shadow still holds zero while it
    // captures the live inputs; bypass it so digit 0 already shows the
    // captured data for its whole first slot.
    assign w_val_src = r_first ? value : r_val_sh;
    assign w_dp_src  = r_first ? dp_in : r_dp_sh;
    assign w_nib     = w_val_src[r_idx*4 +: 4];
    assign w_onehot  = c_one << r_idx;

    // Positive-polarity decode, bit order abcdefg
    always_comb begin
        w_dec = 7'b0000000;
        case (w_nib)
            4'h0: w_dec = 7'b1111110;
            4'h1: w_dec = 7'b0110000;
            4'h2: w_dec = 7'b1101101;
            4'h3: w_dec = 7'b1111001;
            4'h4: w_dec = 7'b0110011;
            4'h5: w_dec = 7'b1011011;
            4'h6: w_dec = 7'b1011111;
            4'h7: w_dec = 7'b1110000;
            4'h8: w_dec = 7'b1111111;
            4'h9: w_dec = 7'b1110011;
            4'hA: w_dec = hex_en ? 7'b1110111 : 7'b0000000;
            4'hB: w_dec = hex_en ? 7'b0011111 : 7'b0000000;
            4'hC: w_dec = hex_en ? 7'b1001110 : 7'b0000000;
            4'hD: w_dec = hex_en ? 7'b0111101 : 7'b0000000;
            4'hE: w_dec = hex_en ? 7'b1001111 : 7'b0000000;
            4'hF: w_dec = hex_en ? 7'b1000111 : 7'b0000000;
            default: w_dec = 7'b0000000;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every more significant digit are zero.
    logic [N_DIGITS-1:0] w_blank;
    logic                w_zero_run;

    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (w_val_src[k*4 +: 4] != 4'h0) begin
                w_zero_run = 1'b0;
            end
            w_blank[k] = w_zero_run;
        end
    end

    assign w_blank_cur = w_blank[r_idx];
`else
    assign w_blank_cur = 1'b0;
`endif

    assign w_seg_pos = w_blank_cur ? 7'b0000000 : w_dec;

    // Output registers; polarity applied by XOR with c_pol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= {7{c_pol}};
            r_dp    <= c_pol;
            r_anode <= {N_DIGITS{c_pol}};
        end else begin
            r_seg   <= w_seg_pos ^ {7{c_pol}};
            r_dp    <= w_dp_src[r_idx] ^ c_pol;
            r_anode <= w_onehot ^ {N_DIGITS{c_pol}};
        end
    end

    assign seg   = r_seg;
    assign dp    = r_dp;
    assign anode = r_anode;

endmodule
`default_nettype wire

// File: doc/display_mux_7seg.md
DISPLAY_MUX_7SEG -- requirements
Module: display_mux_7seg

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit is held (>=2).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = segments, dp and anodes driven active-low, 0 = active-high.
REQ-004 clk  input  1  single clock; all state rising-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 value  input  4*N_DIGITS  digit codes; nibble k = digit k, digit 0 least significant (rightmost).
REQ-007 dp_in  input  N_DIGITS  decimal point request per digit.
REQ-008 hex_en  input  1  1 = decode 10..15 as A,b,C,d,E,F; 0 = BCD only.
REQ-009 seg  output  7  segment drive, bit order abcdefg (seg[6]=a), registered.
REQ-010 dp  output  1  decimal point drive, registered.
REQ-011 anode  output  N_DIGITS  digit enables, one-hot active, registered.

Function
REQ-012 Prescaler cnt counts 0..REFRESH_DIV-1 and wraps; tick asserted when cnt==REFRESH_DIV-1.
REQ-013 Digit index idx advances on tick, wrapping N_DIGITS-1 -> 0; idx otherwise holds.
REQ-014 Shadow register loads value and dp_in on the edge where tick occurs with idx==N_DIGITS-1, and on the first rising edge after rst_n deasserts; it holds otherwise, so a frame never mixes old and new data.
REQ-015 Output registers update every edge from current idx and shadow; outputs lag idx by exactly 1 cycle; each digit is active for exactly REFRESH_DIV consecutive cycles.
REQ-016 anode has exactly one active bit, at position idx; all others inactive.
REQ-017 Decode (positive polarity, abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
REQ-018 With hex_en=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-019 With hex_en=0, codes 10..15 produce all segments off; anode stays active; dp still follows dp_in; no X on any output.
REQ-020 hex_en is sampled live (not shadowed) and affects output the next cycle.
REQ-021 ACTIVE_LOW=1 inverts seg, dp and anode relative to the positive-polarity definition; ACTIVE_LOW=0 drives them unmodified.

Reset
REQ-022 While rst_n=0: cnt=0, idx=0, shadow=0, all anodes inactive, all segments off, dp off (inactive levels per ACTIVE_LOW).
REQ-023 Reset assertion mid-digit or mid-frame takes effect immediately without waiting for clk; the first digit shown after release is digit 0, for a full REFRESH_DIV cycles, using value captured on the first post-reset edge.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, digits from N_DIGITS-1 downward whose shadow nibble is 0 are blanked (segments off, anode still active, dp follows dp_in) up to the first non-zero digit; digit 0 is never blanked.
REQ-025 Without LEADING_ZERO_BLANK_EN every digit displays its decoded code; no blanking logic is present.

Verification (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless noted)
REQ-026 Hold rst_n=0 -> anode=1111, seg=1111111, dp=1; release with value=16'h1234, hex_en=0 -> anode 1110/seg 1001100 for 4 cycles, then 1101/0000110, 1011/0010010, 0111/1001111, repeating.
REQ-027 value=16'hABCD, hex_en=1 -> digits 0..3 show seg 1000010, 0110001, 1100000, 0001000; hex_en=0 -> seg=1111111 every digit, anode still cycling.
REQ-028 Change value from 16'h1234 to 16'h5678 while idx=1 -> digits 1..3 still show 3,2,1; digit 0 of next frame shows 8.
REQ-029 value=16'h0050, dp_in=4'b0100 -> with macro: digits 3 and 2 blank, digit 2 dp=0, digit 1 "5", digit 0 "0"; without macro: "0","0","5","0"; value=16'h0000 with macro -> only digit 0 shows "0".
REQ-030 Assert rst_n=0 between clock edges while idx=2 -> outputs go inactive before next edge; after release, anode=1110 held exactly 4 cycles.
